schedule_1st: RTL and testbench
===============================

# schedule_1st

First scheduler stage, sitting on the receiving end of the decode stage's output bus (valid, PC, opcode, rd/rs1/rs2, funct3/funct7, imm). It buffers decoded instructions in a small in-order FIFO and tracks pending destination registers in a 32-entry busy scoreboard. It issues the oldest instruction to the execute stage only when no read-after-write (RAW) or write-after-write (WAW) hazard exists. It also applies backpressure to the decoder and drains its queue on pipeline flush.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- DECODE_2ND_VALID  in  1  decoded instruction present this cycle.
- DECODE_2ND_PC  in  32  instruction PC.
- DECODE_2ND_OPCODE  in  7  opcode.
- DECODE_2ND_RD / _RS1 / _RS2  in  5 each  register indices.
- DECODE_2ND_FUNCT3  in  3; DECODE_2ND_FUNCT7  in  7.
- DECODE_2ND_IMM  in  32  selected immediate.
- SCHEDULE_1ST_STALL  out  1  queue full; decoder must hold its instruction.
- FLUSH  in  1  discard all queued instructions.
- WB_VALID  in  1  a register write completes this cycle.
- WB_RD  in  5  register written.
- SCHEDULE_1ST_VALID  out  1  head instruction issuable.
- SCHEDULE_1ST_PC, _OPCODE, _RD, _RS1, _RS2, _FUNCT3, _FUNCT7, _IMM  out  widths as inputs  head instruction fields.
- EXEC_READY  in  1  execute accepts the issued instruction this cycle.

## Operation
- Push: DECODE_2ND_VALID && !SCHEDULE_1ST_STALL && !FLUSH writes the input fields at the tail; write pointer increments modulo DEPTH.
- STALL = (count == DEPTH), decoded from registered count only. A pop in the same cycle does not unblock a push.
- Head fields are driven directly from the head FIFO slot. When empty, field outputs are don't-care and VALID=0.
- writes_rd = opcode ∈ {0110011, 0010011, 0000011, 1100111, 1110011, 0110111, 0010111, 1101111} and rd≠0. It is 0 for 0100011 (S), 1100011 (B), and 0001111 (fence).
- Hazard: busy[rs1] | busy[rs2] | (writes_rd & busy[rd]). busy[0] is hard-wired to 0.
- Reads use the registered busy vector only; there is no writeback bypass.
- SCHEDULE_1ST_VALID = !empty && !hazard && !FLUSH.
- Issue = VALID && EXEC_READY:
  - head pointer increments modulo DEPTH;
  - if writes_rd, busy[rd] is set at the edge.
- WB_VALID clears busy[WB_RD] at the edge.
  - Same-cycle issue setting and WB clearing the same register: set wins.
  - WB_RD=0 has no effect.
- Count:
  - +1 on push only;
  - −1 on issue only;
  - unchanged on push and issue together.
- FLUSH: read pointer, write pointer and count go to 0 at the edge. A concurrent push is discarded; no issue occurs that cycle. The scoreboard is preserved, because in-flight instructions still write back.

## Timing
- Reset (RST low, asynchronous):
  - count = 0, pointers = 0, busy = 0;
  - SCHEDULE_1ST_VALID = 0, STALL = 0;
  - field outputs = 0.
- Release of RST is synchronous to CLK.
- Latency: an instruction pushed at edge N into an empty, hazard-free queue shows VALID=1 in cycle N+1. Throughput is 1 issue per cycle.
- Dependent back-to-back pair (B reads A's rd):
  - A issues at edge N; busy is set in cycle N+1, stalling B.
  - WB at edge M clears busy; B is VALID in cycle M+1.
- VALID and the head fields remain stable while EXEC_READY=0, unless FLUSH or an asynchronous reset occurs.
- Pointer wrap: DEPTH consecutive pushes and issues cycle each pointer through 0..DEPTH−1 and back to 0 without loss or reordering.

## Test plan
- Reset: hold RST=0 mid-traffic with 3 entries queued -> VALID=0, STALL=0, and next pushes start at slot 0. Previously queued PCs are never issued.
- Fill/backpressure: EXEC_READY=0; push PCs 0x00,0x04,0x08,0x0C,0x10 -> STALL=1 after the 4th push, 0x10 is held. With EXEC_READY=1 issue order is 0x00..0x10, with 0x10 accepted one cycle after the first pop.
- RAW: push `addi x5,x0,1` then `add x6,x5,x5`; EXEC_READY=1 -> the first issues, the second has VALID=0 until WB_VALID/WB_RD=5, then issues the next cycle.
- No false hazards: `sw x5,0(x2)` with busy[5]=0 and `beq` with rd field=5 while busy[5]=1 -> the store issues; `beq` is blocked only via its rs fields. An instruction with rd=0 never sets busy.
- Simultaneous set/clear: issue `addi x7,...` in the same cycle as WB_VALID with WB_RD=7 -> busy[7]=1 afterwards, and a following reader of x7 stalls.
- Flush: 3 queued, FLUSH=1 with DECODE_2ND_VALID=1 -> the queue is empty next cycle, the incoming instruction is dropped, and busy bits are unchanged.

Source files
------------

// File: rtl/schedule_1st.sv
// First scheduler stage: in-order instruction FIFO plus a 32-entry busy
// scoreboard; issues the head instruction only when it has no RAW/WAW hazard.
module schedule_1st #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,

  input  logic        DECODE_2ND_VALID,
  input  logic [31:0] DECODE_2ND_PC,
  input  logic [6:0]  DECODE_2ND_OPCODE,
  input  logic [4:0]  DECODE_2ND_RD,
  input  logic [4:0]  DECODE_2ND_RS1,
  input  logic [4:0]  DECODE_2ND_RS2,
  input  logic [2:0]  DECODE_2ND_FUNCT3,
  input  logic [6:0]  DECODE_2ND_FUNCT7,
  input  logic [31:0] DECODE_2ND_IMM,
  output logic        SCHEDULE_1ST_STALL,

  input  logic        FLUSH,
  input  logic        WB_VALID,
  input  logic [4:0]  WB_RD,

  output logic        SCHEDULE_1ST_VALID,
  output logic [31:0] SCHEDULE_1ST_PC,
  output logic [6:0]  SCHEDULE_1ST_OPCODE,
  output logic [4:0]  SCHEDULE_1ST_RD,
  output logic [4:0]  SCHEDULE_1ST_RS1,
  output logic [4:0]  SCHEDULE_1ST_RS2,
  output logic [2:0]  SCHEDULE_1ST_FUNCT3,
  output logic [6:0]  SCHEDULE_1ST_FUNCT7,
  output logic [31:0] SCHEDULE_1ST_IMM,
  input  logic        EXEC_READY
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } entry_t;

  entry_t             fifo_q [DEPTH];
  entry_t             in_entry;
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [31:0]        busy_q;
  logic [31:0]        busy_d;

  logic               empty;
  logic               full;
  logic               push;
  logic               issue;
  logic               writes_rd;
  logic               hazard;
  logic               valid;

  always_comb begin
    in_entry        = '0;
    in_entry.pc     = DECODE_2ND_PC;
    in_entry.opcode = DECODE_2ND_OPCODE;
    in_entry.rd     = DECODE_2ND_RD;
    in_entry.rs1    = DECODE_2ND_RS1;
    in_entry.rs2    = DECODE_2ND_RS2;
    in_entry.funct3 = DECODE_2ND_FUNCT3;
    in_entry.funct7 = DECODE_2ND_FUNCT7;
    in_entry.imm    = DECODE_2ND_IMM;
  end

  assign head  = fifo_q[rd_ptr_q];
  assign empty = (count_q == '0);
  // Backpressure looks only at the registered count; a same-cycle pop does not free a slot.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign push  = DECODE_2ND_VALID && !full && !FLUSH;

  always_comb begin
    writes_rd = 1'b0;
    if (head.rd != '0) begin
      writes_rd = head.opcode inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                                      7'b1110011, 7'b0110111, 7'b0010111, 7'b1101111};
    end
  end

  assign hazard = busy_q[head.rs1] | busy_q[head.rs2] | (writes_rd & busy_q[head.rd]);
  assign valid  = !empty && !hazard && !FLUSH;
  assign issue  = valid && EXEC_READY;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q] <= in_entry;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (FLUSH) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (issue) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, issue})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Issue-set is applied after the writeback clear so it wins on the same register.
  always_comb begin
    busy_d = busy_q;
    if (WB_VALID) begin
      busy_d[WB_RD] = 1'b0;
    end
    if (issue && writes_rd) begin
      busy_d[head.rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign SCHEDULE_1ST_STALL  = full;
  assign SCHEDULE_1ST_VALID  = valid;
  assign SCHEDULE_1ST_PC     = head.pc;
  assign SCHEDULE_1ST_OPCODE = head.opcode;
  assign SCHEDULE_1ST_RD     = head.rd;
  assign SCHEDULE_1ST_RS1    = head.rs1;
  assign SCHEDULE_1ST_RS2    = head.rs2;
  assign SCHEDULE_1ST_FUNCT3 = head.funct3;
  assign SCHEDULE_1ST_FUNCT7 = head.funct7;
  assign SCHEDULE_1ST_IMM    = head.imm;

endmodule

// File: tb/tb_schedule_1st.sv
// Directed bench for schedule_1st: per-cycle vector table plus hand-written
// flush and mid-traffic reset sequences.
module tb_schedule_1st;

  logic        CLK;
  logic        RST;
  logic        DECODE_2ND_VALID;
  logic [31:0] DECODE_2ND_PC;
  logic [6:0]  DECODE_2ND_OPCODE;
  logic [4:0]  DECODE_2ND_RD;
  logic [4:0]  DECODE_2ND_RS1;
  logic [4:0]  DECODE_2ND_RS2;
  logic [2:0]  DECODE_2ND_FUNCT3;
  logic [6:0]  DECODE_2ND_FUNCT7;
  logic [31:0] DECODE_2ND_IMM;
  logic        SCHEDULE_1ST_STALL;
  logic        FLUSH;
  logic        WB_VALID;
  logic [4:0]  WB_RD;
  logic        SCHEDULE_1ST_VALID;
  logic [31:0] SCHEDULE_1ST_PC;
  logic [6:0]  SCHEDULE_1ST_OPCODE;
  logic [4:0]  SCHEDULE_1ST_RD;
  logic [4:0]  SCHEDULE_1ST_RS1;
  logic [4:0]  SCHEDULE_1ST_RS2;
  logic [2:0]  SCHEDULE_1ST_FUNCT3;
  logic [6:0]  SCHEDULE_1ST_FUNCT7;
  logic [31:0] SCHEDULE_1ST_IMM;
  logic        EXEC_READY;

  schedule_1st #(.DEPTH(4)) dut (
    .CLK                (CLK),
    .RST                (RST),
    .DECODE_2ND_VALID   (DECODE_2ND_VALID),
    .DECODE_2ND_PC      (DECODE_2ND_PC),
    .DECODE_2ND_OPCODE  (DECODE_2ND_OPCODE),
    .DECODE_2ND_RD      (DECODE_2ND_RD),
    .DECODE_2ND_RS1     (DECODE_2ND_RS1),
    .DECODE_2ND_RS2     (DECODE_2ND_RS2),
    .DECODE_2ND_FUNCT3  (DECODE_2ND_FUNCT3),
    .DECODE_2ND_FUNCT7  (DECODE_2ND_FUNCT7),
    .DECODE_2ND_IMM     (DECODE_2ND_IMM),
    .SCHEDULE_1ST_STALL (SCHEDULE_1ST_STALL),
    .FLUSH              (FLUSH),
    .WB_VALID           (WB_VALID),
    .WB_RD              (WB_RD),
    .SCHEDULE_1ST_VALID (SCHEDULE_1ST_VALID),
    .SCHEDULE_1ST_PC    (SCHEDULE_1ST_PC),
    .SCHEDULE_1ST_OPCODE(SCHEDULE_1ST_OPCODE),
    .SCHEDULE_1ST_RD    (SCHEDULE_1ST_RD),
    .SCHEDULE_1ST_RS1   (SCHEDULE_1ST_RS1),
    .SCHEDULE_1ST_RS2   (SCHEDULE_1ST_RS2),
    .SCHEDULE_1ST_FUNCT3(SCHEDULE_1ST_FUNCT3),
    .SCHEDULE_1ST_FUNCT7(SCHEDULE_1ST_FUNCT7),
    .SCHEDULE_1ST_IMM   (SCHEDULE_1ST_IMM),
    .EXEC_READY         (EXEC_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;

  typedef struct {
    logic        dv;
    logic [31:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        flush;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        rdy;
    logic        exp_valid;
    logic        exp_stall;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t V(logic dv, logic [31:0] pc, logic [6:0] op,
                             logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                             logic flush, logic wbv, logic [4:0] wbrd, logic rdy,
                             logic ev, logic es, logic [31:0] epc);
    vec_t v;
    v.dv = dv; v.pc = pc; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.flush = flush; v.wbv = wbv; v.wbrd = wbrd; v.rdy = rdy;
    v.exp_valid = ev; v.exp_stall = es; v.exp_pc = epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    DECODE_2ND_VALID  = v.dv;
    DECODE_2ND_PC     = v.pc;
    DECODE_2ND_OPCODE = v.op;
    DECODE_2ND_RD     = v.rd;
    DECODE_2ND_RS1    = v.rs1;
    DECODE_2ND_RS2    = v.rs2;
    DECODE_2ND_FUNCT3 = v.pc[4:2];
    DECODE_2ND_FUNCT7 = v.pc[10:4];
    DECODE_2ND_IMM    = ~v.pc;
    FLUSH             = v.flush;
    WB_VALID          = v.wbv;
    WB_RD             = v.wbrd;
    EXEC_READY        = v.rdy;
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, then advance past the edge.
  task automatic step(input string name, input vec_t v);
    logic [31:0] epc;
    epc = v.exp_pc;
    apply(v);
    @(negedge CLK);
    chk({name, ".valid"}, {31'b0, SCHEDULE_1ST_VALID}, {31'b0, v.exp_valid});
    chk({name, ".stall"}, {31'b0, SCHEDULE_1ST_STALL}, {31'b0, v.exp_stall});
    if (v.exp_valid) begin
      chk({name, ".pc"}, SCHEDULE_1ST_PC, epc);
      chk({name, ".imm"}, SCHEDULE_1ST_IMM, ~epc);
      chk({name, ".funct3"}, {29'b0, SCHEDULE_1ST_FUNCT3}, {29'b0, epc[4:2]});
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    apply(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset.valid", {31'b0, SCHEDULE_1ST_VALID}, 32'd0);
    chk("reset.stall", {31'b0, SCHEDULE_1ST_STALL}, 32'd0);
    chk("reset.pc", SCHEDULE_1ST_PC, 32'd0);
    chk("reset.imm", SCHEDULE_1ST_IMM, 32'd0);
    chk("reset.opcode", {25'b0, SCHEDULE_1ST_OPCODE}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Fill to full with execute blocked, then drain; write pointer wraps.
    tbl.push_back(V(1, 'h00, OPI, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00));
    tbl.push_back(V(1, 'h04, OPI, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h00));
    tbl.push_back(V(1, 'h08, OPI, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h00));
    tbl.push_back(V(1, 'h0C, OPI, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h00));
    tbl.push_back(V(1, 'h10, OPI, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h00));
    tbl.push_back(V(1, 'h10, OPI, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h00));
    tbl.push_back(V(1, 'h10, OPI, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'h04));
    tbl.push_back(V(0, 'h00, OPI, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'h08));
    tbl.push_back(V(0, 'h00, OPI, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'h0C));
    tbl.push_back(V(0, 'h00, OPI, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'h10));
    tbl.push_back(V(0, 'h00, OPI, 0, 0, 0, 0, 0, 0, 1, 0, 0, 'h00));
    // RAW: addi x5,x0,1 ; add x6,x5,x5
    tbl.push_back(V(1, 'h100, OPI, 5, 0, 0, 0, 0, 0, 1, 0, 0, 'h000));
    tbl.push_back(V(1, 'h104, OP,  6, 5, 5, 0, 0, 0, 1, 1, 0, 'h100));
    tbl.push_back(V(0, 'h000, OP,  0, 0, 0, 0, 0, 0, 1, 0, 0, 'h000));
    tbl.push_back(V(0, 'h000, OP,  0, 0, 0, 0, 0, 0, 1, 0, 0, 'h000));
    tbl.push_back(V(0, 'h000, OP,  0, 0, 0, 0, 1, 5, 1, 0, 0, 'h000));
    tbl.push_back(V(0, 'h000, OP,  0, 0, 0, 0, 0, 0, 1, 1, 0, 'h104));
    tbl.push_back(V(0, 'h000, OP,  0, 0, 0, 0, 0, 0, 1, 0, 0, 'h000));
    tbl.push_back(V(0, 'h000, OP,  0, 0, 0, 0, 1, 6, 1, 0, 0, 'h000));
    // Store rd field never sets busy; rd=0 writer never blocks
    tbl.push_back(V(1, 'h200, ST,  3, 2, 5, 0, 0, 0, 1, 0, 0, 'h000));
    tbl.push_back(V(0, 'h000, OP,  0, 0, 0, 0, 0, 0, 1, 1, 0, 'h200));
    tbl.push_back(V(1, 'h204, OP,  0, 3, 0, 0, 0, 0, 1, 0, 0, 'h000));
    tbl.push_back(V(0, 'h000, OP,  0, 0, 0, 0, 0, 0, 1, 1, 0, 'h204));
    // Branch with rd=5 while busy[5]; then WAW and rs2 hazards
    tbl.push_back(V(1, 'h210, OPI, 5, 0, 0, 0, 0, 0, 1, 0, 0, 'h000));
    tbl.push_back(V(0, 'h000, OP,  0, 0, 0, 0, 0, 0, 1, 1, 0, 'h210));
    tbl.push_back(V(1, 'h214, BR,  5, 1, 2, 0, 0, 0, 1, 0, 0, 'h000));
    tbl.push_back(V(0, 'h000, OP,  0, 0, 0, 0, 0, 0, 1, 1, 0, 'h214));
    tbl.push_back(V(1, 'h218, OPI, 5, 1, 0, 0, 0, 0, 1, 0, 0, 'h000));
    tbl.push_back(V(1, 'h21C, BR,  0, 1, 5, 0, 0, 0, 1, 0, 0, 'h000));
    tbl.push_back(V(0, 'h000, OP,  0, 0, 0, 0, 1, 5, 1, 0, 0, 'h000));
    tbl.push_back(V(0, 'h000, OP,  0, 0, 0, 0, 0, 0, 1, 1, 0, 'h218));
    tbl.push_back(V(0, 'h000, OP,  0, 0, 0, 0, 0, 0, 1, 0, 0, 'h000));
    tbl.push_back(V(0, 'h000, OP,  0, 0, 0, 0, 1, 5, 1, 0, 0, 'h000));
    tbl.push_back(V(0, 'h000, OP,  0, 0, 0, 0, 0, 0, 1, 1, 0, 'h21C));
    tbl.push_back(V(0, 'h000, OP,  0, 0, 0, 0, 0, 0, 1, 0, 0, 'h000));
    // Issue of addi x7 coincides with WB x7: busy[7] must stay set
    tbl.push_back(V(1, 'h300, OPI, 7, 0, 0, 0, 0, 0, 1, 0, 0, 'h000));
    tbl.push_back(V(1, 'h304, OP,  8, 7, 0, 0, 1, 7, 1, 1, 0, 'h300));
    tbl.push_back(V(0, 'h000, OP,  0, 0, 0, 0, 0, 0, 1, 0, 0, 'h000));
    tbl.push_back(V(0, 'h000, OP,  0, 0, 0, 0, 1, 7, 1, 0, 0, 'h000));
    tbl.push_back(V(0, 'h000, OP,  0, 0, 0, 0, 0, 0, 1, 1, 0, 'h304));
    tbl.push_back(V(0, 'h000, OP,  0, 0, 0, 0, 1, 8, 1, 0, 0, 'h000));

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i]);
    end

    // Flush with 3 queued and a concurrent push; busy[9] survives the flush.
    step("fl0", V(1, 'h3F0, OPI, 9, 0, 0, 0, 0, 0, 0, 0, 0, 'h000));
    step("fl1", V(1, 'h400, OPI, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'h3F0));
    step("fl2", V(1, 'h404, OPI, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h400));
    step("fl3", V(1, 'h408, OPI, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h400));
    step("fl4", V(1, 'h40C, OPI, 0, 0, 0, 1, 0, 0, 1, 0, 0, 'h000));
    step("fl5", V(0, 'h000, OP,  0, 0, 0, 0, 0, 0, 1, 0, 0, 'h000));
    step("fl6", V(1, 'h410, OP,  1, 9, 0, 0, 0, 0, 1, 0, 0, 'h000));
    step("fl7", V(0, 'h000, OP,  0, 0, 0, 0, 0, 0, 1, 0, 0, 'h000));
    step("fl8", V(0, 'h000, OP,  0, 0, 0, 0, 1, 9, 1, 0, 0, 'h000));
    step("fl9", V(0, 'h000, OP,  0, 0, 0, 0, 0, 0, 1, 1, 0, 'h410));
    step("fl10", V(0, 'h000, OP, 0, 0, 0, 0, 1, 1, 1, 0, 0, 'h000));

    // Asynchronous reset mid-traffic with 3 entries queued and busy[10] set.
    step("rs0", V(1, 'h4F0, OPI, 10, 0, 0, 0, 0, 0, 0, 0, 0, 'h000));
    step("rs1", V(1, 'h500, OPI, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'h4F0));
    step("rs2", V(1, 'h504, OPI, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h500));
    step("rs3", V(1, 'h508, OPI, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h500));
    apply(V(0, 0, OP, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    #2;
    chk("rs.pre_valid", {31'b0, SCHEDULE_1ST_VALID}, 32'd1);
    RST = 1'b0;
    #1;
    chk("rs.async_valid", {31'b0, SCHEDULE_1ST_VALID}, 32'd0);
    chk("rs.async_stall", {31'b0, SCHEDULE_1ST_STALL}, 32'd0);
    chk("rs.async_pc", SCHEDULE_1ST_PC, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    step("rs4", V(1, 'h600, OP, 11, 10, 0, 0, 0, 0, 1, 0, 0, 'h000));
    step("rs5", V(0, 'h000, OP, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'h600));
    step("rs6", V(0, 'h000, OP, 0, 0, 0, 0, 0, 0, 1, 0, 0, 'h000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
